// File: rtl/input_pkg.sv
// Shared types and defaults for the board input conditioner.
// Event bundle handed from the arbiter to the output register.
package input_pkg;

    localparam int NUM_CH_DEF       = 4;
    localparam int TICK_DIV_DEF     = 1000;
    localparam int STABLE_TICKS_DEF = 4;
    localparam int CH_W             = $clog2(NUM_CH_DEF);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            rise;
    } evt_t;

endpackage

// File: rtl/debounce_chan.sv
// One input channel: 2-flop synchronizer, tick-based debounce,
// pending-event flag with direction and overwrite detect.
module debounce_chan #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic tick_i,
    input  logic grant_clr_i,
    output logic level_o,
    output logic pend_o,
    output logic dir_o,
    output logic ovf_set_o
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pend_q, pend_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          set;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        set     = 1'b0;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
                set     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A fresh edge beats a same-cycle grant so it is never lost.
    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        if (set) begin
            pend_d = 1'b1;
            dir_d  = sync2_q;
        end else if (grant_clr_i) begin
            pend_d = 1'b0;
        end
    end

    assign ovf_set_o = set && pend_q && !grant_clr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pend_q  <= 1'b0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign pend_o  = pend_q;
    assign dir_o   = dir_q;

endmodule

// File: rtl/input_debounce_ctrl.sv
// Multi-channel debounce with shared tick prescaler and a
// round-robin arbiter driving one valid/ready edge-event port.
module input_debounce_ctrl
    import input_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         in_raw,
    output logic [NUM_CH-1:0]         level,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_rise,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(NUM_CH);

    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic [NUM_CH-1:0] pend, dir, ovf_set, grant_clr;
    logic [CW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     grant_idx;
    logic              grant_vld;
    logic              load;
    logic              evt_valid_q, evt_valid_d;
    evt_t              evt_q, evt_d;
    logic              ovf_q, ovf_d;

    assign tick  = en && (pre_q == PW'(TICK_DIV - 1));
    assign pre_d = !en ? pre_q : (tick ? '0 : pre_q + 1'b1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .raw_i      (in_raw[i]),
            .tick_i     (tick),
            .grant_clr_i(grant_clr[i]),
            .level_o    (level[i]),
            .pend_o     (pend[i]),
            .dir_o      (dir[i]),
            .ovf_set_o  (ovf_set[i])
        );
    end

    // Scan from rr_q upward, wrapping, first pending channel wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (!grant_vld && pend[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    assign load = !evt_valid_q || evt_ready;

    always_comb begin
        grant_clr   = '0;
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        rr_d        = rr_q;
        if (load) begin
            evt_valid_d = grant_vld;
            if (grant_vld) begin
                grant_clr[grant_idx] = 1'b1;
                evt_d.ch   = grant_idx;
                evt_d.rise = dir[grant_idx];
                rr_d = (grant_idx == CW'(NUM_CH - 1)) ? '0
                                                      : grant_idx + 1'b1;
            end
        end
    end

    assign ovf_d = (|ovf_set) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_q.ch;
    assign evt_rise  = evt_q.rise;
    assign ovf       = ovf_q;

endmodule
